vco_freq_ctrl: RTL and testbench
================================

Name: vco_freq_ctrl

Overview:
- Frequency-locked-loop controller that sequences the `vco` block.
- Drives the VCO `voltage_ctrl_i` word from `voltage_ctrl_o`.
- Each measurement window, it counts VCO cycles and compares the count to a requested target count. It then steps the control word until the count is within tolerance.
- Runs entirely in the reference clock domain. `vco_count_i` is a free-running VCO-cycle counter, already synchronised into `clk_i` by the prescaler/synchroniser in front of it.

Parameters:
- RESOLUTION_BITS, 30, width of the VCO control word.
- CNT_W, 32, width of the count, target and measurement values.
- WINDOW_CYCLES, 1024, `clk_i` cycles per measurement window.
- SETTLE_CYCLES, 16, `clk_i` cycles waited after any control change before a window starts.
- GAIN_SHIFT, 2, step = |error| >> GAIN_SHIFT.
- LOCK_TOL, 1, maximum |error| (counts) treated as on-target.
- LOCK_WINDOWS, 4, consecutive on-target windows required to assert lock.
- MAX_ITER, 255, adjustment steps allowed per acquisition before failure.

Ports:
- clk_i  in  1  reference clock.
- rst_i  in  1  synchronous, active-high reset.
- target_i  in  CNT_W  requested VCO cycles per window.
- target_valid_i  in  1  target offer.
- target_ready_o  out  1  target accept.
- vco_count_i  in  CNT_W  free-running VCO cycle count; wraps mod 2^CNT_W.
- voltage_ctrl_o  out  RESOLUTION_BITS  control word to the `vco` block.
- meas_o  out  CNT_W  count from the most recent completed window.
- locked_o  out  1  frequency locked.
- busy_o  out  1  acquisition in progress.
- fail_o  out  1  target unreachable or iteration limit hit.

Behaviour:
- Reset (synchronous, rst_i=1 at posedge):
  - state=IDLE.
  - voltage_ctrl_o=0, meas_o=0, locked_o=0, busy_o=0, fail_o=0, target_ready_o=1.
  - All counters cleared.
  - Reset asserted mid-window aborts immediately, with no partial update.
- Handshake:
  - Transfer occurs when target_valid_i && target_ready_o at a posedge.
  - target_ready_o=1 in every state except ADJUST.
  - On transfer:
    - Latch target_i.
    - Clear locked_o, fail_o, the iteration counter and the lock streak.
    - Set busy_o=1 and go to SETTLE.
    - voltage_ctrl_o is retained, so acquisition starts from the current word.
  - A transfer in SETTLE/MEASURE/LOCKED/FAIL aborts the current window and restarts.
- States: IDLE, SETTLE, MEASURE, ADJUST, FAIL.
- SETTLE:
  - Count SETTLE_CYCLES cycles.
  - On the last cycle, capture start=vco_count_i and go to MEASURE.
- MEASURE:
  - Count WINDOW_CYCLES cycles.
  - On the last cycle, meas_o <= vco_count_i - start, modulo 2^CNT_W. Wrap of vco_count_i is therefore transparent.
  - Go to ADJUST.
- ADJUST (exactly one cycle):
  - err = target - meas_o, signed CNT_W+1 bits.
  - If |err| <= LOCK_TOL:
    - streak++ (saturating at LOCK_WINDOWS).
    - If streak == LOCK_WINDOWS: locked_o=1, busy_o=0.
    - voltage_ctrl_o unchanged; next state is SETTLE.
  - Else:
    - streak=0.
    - If locked_o was 1: clear it, set busy_o=1, reset the iteration counter.
    - step = max(1, |err|>>GAIN_SHIFT), clipped to 2^RESOLUTION_BITS-1.
    - err>0: voltage += step, saturating at all-ones.
    - err<0: voltage -= step, saturating at 0.
    - iter++ on every step.
  - Failure: if the word was already at all-ones with err>LOCK_TOL, or at 0 with err<-LOCK_TOL, or iter reaches MAX_ITER:
    - fail_o=1, busy_o=0, voltage unchanged, next state is FAIL.
- Tracking: after lock, the SETTLE→MEASURE→ADJUST cycle continues indefinitely, so drift is re-acquired automatically.
- FAIL:
  - Holds all outputs.
  - Leaves only on a new target or reset.
- Latency from a voltage change to its next evaluation: SETTLE_CYCLES + WINDOW_CYCLES + 1 cycles.

Test Plan:
- Bench VCO model: vco_count_i += voltage_ctrl_o[29:20] every clk_i cycle, giving meas = 1024 × voltage_ctrl_o[29:20].
- Reset, then idle 50 cycles -> voltage_ctrl_o=0, target_ready_o=1, locked_o=0, busy_o=0, fail_o=0.
- target_i=512000 from voltage 0 -> voltage_ctrl_o[29:20] converges to 500, meas_o=512000, locked_o=1 after 4 on-target windows, iter<MAX_ITER, fail_o=0.
- Locked at 512000, then model offset +3 counts per cycle -> locked_o drops at the next ADJUST, busy_o=1, relocks within ≤10 windows.
- target_i=2000000 (max achievable 1047552) -> voltage saturates at 0x3FFFFFFF, then fail_o=1 on the next ADJUST; locked_o=0, busy_o=0.
- Preload vco_count_i=0xFFFFFF00 with target 512000 -> meas_o correct across the wrap, lock identical to the lock scenario.
- Retarget during MEASURE (valid for 1 cycle) -> window aborted, new target latched, SETTLE restarts. Assert rst_i mid-MEASURE -> all outputs return to reset values on the next cycle.

Source files
------------

// File: rtl/vco_freq_ctrl.sv
// Frequency-locked-loop controller for the vco block.
// Each window it counts VCO cycles, compares the count against the requested
// target and steps the control word until the count stays within tolerance.
module vco_freq_ctrl #(
    parameter int unsigned RESOLUTION_BITS = 30,
    parameter int unsigned CNT_W           = 32,
    parameter int unsigned WINDOW_CYCLES   = 1024,
    parameter int unsigned SETTLE_CYCLES   = 16,
    parameter int unsigned GAIN_SHIFT      = 2,
    parameter int unsigned LOCK_TOL        = 1,
    parameter int unsigned LOCK_WINDOWS    = 4,
    parameter int unsigned MAX_ITER        = 255
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [CNT_W-1:0]           target_i,
    input  logic                       target_valid_i,
    output logic                       target_ready_o,
    input  logic [CNT_W-1:0]           vco_count_i,
    output logic [RESOLUTION_BITS-1:0] voltage_ctrl_o,
    output logic [CNT_W-1:0]           meas_o,
    output logic                       locked_o,
    output logic                       busy_o,
    output logic                       fail_o
);

    localparam int unsigned RB       = RESOLUTION_BITS;
    localparam int unsigned TMAX     = (WINDOW_CYCLES > SETTLE_CYCLES) ? WINDOW_CYCLES
                                                                       : SETTLE_CYCLES;
    localparam int unsigned TIMER_W  = $clog2(TMAX + 1);
    localparam int unsigned ITER_W   = $clog2(MAX_ITER + 1);
    localparam int unsigned STREAK_W = $clog2(LOCK_WINDOWS + 1);
    localparam int unsigned WW       = (CNT_W > RB) ? CNT_W : RB;
    localparam logic [RB-1:0] VMAX   = '1;

    typedef enum logic [2:0] {StIdle, StSettle, StMeasure, StAdjust, StFail} state_e;

    state_e                state_q, state_d;
    logic [TIMER_W-1:0]    timer_q, timer_d;
    logic [CNT_W-1:0]      start_q, start_d;
    logic [CNT_W-1:0]      target_q, target_d;
    logic [CNT_W-1:0]      meas_q, meas_d;
    logic [RB-1:0]         volt_q, volt_d;
    logic [ITER_W-1:0]     iter_q, iter_d;
    logic [STREAK_W-1:0]   streak_q, streak_d;
    logic                  locked_q, locked_d;
    logic                  busy_q, busy_d;
    logic                  fail_q, fail_d;

    logic                  ready;
    logic                  xfer;
    logic [CNT_W:0]        err_raw;
    logic                  err_neg;
    logic [CNT_W:0]        err_mag;
    logic                  on_target;
    logic [WW-1:0]         shifted_w;
    logic [RB-1:0]         step;
    logic [RB:0]           sum;
    logic [RB-1:0]         volt_up;
    logic [RB-1:0]         volt_dn;
    logic                  at_rail;
    logic [ITER_W-1:0]     iter_base;

    assign ready = (state_q != StAdjust);
    assign xfer  = target_valid_i && ready;

    // err = target - meas as a CNT_W+1-bit two's-complement value
    assign err_raw   = {1'b0, target_q} - {1'b0, meas_q};
    assign err_neg   = err_raw[CNT_W];
    assign err_mag   = err_neg ? (~err_raw + (CNT_W+1)'(1)) : err_raw;
    assign on_target = (err_mag <= (CNT_W+1)'(LOCK_TOL));

    // Step size: |err| >> GAIN_SHIFT, at least 1, clipped to the word range
    always_comb begin
        shifted_w = WW'(err_mag[CNT_W-1:0] >> GAIN_SHIFT);
        if (shifted_w == '0) begin
            step = RB'(1);
        end else if (shifted_w > WW'(VMAX)) begin
            step = VMAX;
        end else begin
            step = shifted_w[RB-1:0];
        end
    end

    assign sum     = {1'b0, volt_q} + {1'b0, step};
    assign volt_up = sum[RB] ? VMAX : sum[RB-1:0];
    assign volt_dn = (volt_q < step) ? '0 : (volt_q - step);
    // Already pinned at the rail the error is pushing towards
    assign at_rail = (!err_neg && (volt_q == VMAX)) || (err_neg && (volt_q == '0));

    // Next-state logic: window sequencing, loop update and target handshake
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        start_d   = start_q;
        target_d  = target_q;
        meas_d    = meas_q;
        volt_d    = volt_q;
        iter_d    = iter_q;
        streak_d  = streak_q;
        locked_d  = locked_q;
        busy_d    = busy_q;
        fail_d    = fail_q;
        iter_base = iter_q;

        unique case (state_q)
            StIdle: ;
            StSettle: begin
                if (timer_q == TIMER_W'(SETTLE_CYCLES - 1)) begin
                    start_d = vco_count_i;
                    timer_d = '0;
                    state_d = StMeasure;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            StMeasure: begin
                if (timer_q == TIMER_W'(WINDOW_CYCLES - 1)) begin
                    // Modular difference makes counter wrap transparent
                    meas_d  = vco_count_i - start_q;
                    timer_d = '0;
                    state_d = StAdjust;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            StAdjust: begin
                state_d = StSettle;
                if (on_target) begin
                    if (streak_q != STREAK_W'(LOCK_WINDOWS)) begin
                        streak_d = streak_q + STREAK_W'(1);
                    end
                    if (streak_d == STREAK_W'(LOCK_WINDOWS)) begin
                        locked_d = 1'b1;
                        busy_d   = 1'b0;
                    end
                end else begin
                    streak_d = '0;
                    // Losing lock starts a fresh acquisition with a new step budget
                    if (locked_q) begin
                        locked_d  = 1'b0;
                        busy_d    = 1'b1;
                        iter_base = '0;
                    end
                    if (at_rail || (iter_base == ITER_W'(MAX_ITER))) begin
                        fail_d   = 1'b1;
                        busy_d   = 1'b0;
                        locked_d = 1'b0;
                        iter_d   = iter_base;
                        state_d  = StFail;
                    end else begin
                        volt_d = err_neg ? volt_dn : volt_up;
                        iter_d = iter_base + ITER_W'(1);
                    end
                end
            end
            StFail: ;
            default: state_d = StIdle;
        endcase

        // A new target aborts whatever window is in flight
        if (xfer) begin
            target_d = target_i;
            locked_d = 1'b0;
            fail_d   = 1'b0;
            iter_d   = '0;
            streak_d = '0;
            busy_d   = 1'b1;
            timer_d  = '0;
            state_d  = StSettle;
        end
    end

    // State register with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            timer_q  <= '0;
            start_q  <= '0;
            target_q <= '0;
            meas_q   <= '0;
            volt_q   <= '0;
            iter_q   <= '0;
            streak_q <= '0;
            locked_q <= 1'b0;
            busy_q   <= 1'b0;
            fail_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            start_q  <= start_d;
            target_q <= target_d;
            meas_q   <= meas_d;
            volt_q   <= volt_d;
            iter_q   <= iter_d;
            streak_q <= streak_d;
            locked_q <= locked_d;
            busy_q   <= busy_d;
            fail_q   <= fail_d;
        end
    end

    assign target_ready_o = ready;
    assign voltage_ctrl_o = volt_q;
    assign meas_o         = meas_q;
    assign locked_o       = locked_q;
    assign busy_o         = busy_q;
    assign fail_o         = fail_q;

endmodule

// File: tb/tb_vco_freq_ctrl.sv
// Directed bench for vco_freq_ctrl.
// Scaled configuration: 10-bit word, 16-cycle window, 4-cycle settle, gain shift 5.
// The VCO model adds (voltage + offset) counts per clock, so meas = 16 * (voltage + offset)
// and a target of 8000 settles at voltage 500. One window = 4 + 16 + 1 = 21 cycles.
module tb_vco_freq_ctrl;

    localparam int unsigned RB  = 10;
    localparam int unsigned CW  = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [CW-1:0] target = '0;
    logic          valid = 1'b0;
    logic          ready;
    logic [CW-1:0] vco_count;
    logic [RB-1:0] volt;
    logic [CW-1:0] meas;
    logic          locked;
    logic          busy;
    logic          fail;

    logic [CW-1:0] offset = '0;
    logic          load = 1'b1;
    logic [CW-1:0] load_val = '0;

    int errors = 0;
    int checks = 0;

    vco_freq_ctrl #(
        .RESOLUTION_BITS (RB),
        .CNT_W           (CW),
        .WINDOW_CYCLES   (16),
        .SETTLE_CYCLES   (4),
        .GAIN_SHIFT      (5),
        .LOCK_TOL        (1),
        .LOCK_WINDOWS    (4),
        .MAX_ITER        (255)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .target_i       (target),
        .target_valid_i (valid),
        .target_ready_o (ready),
        .vco_count_i    (vco_count),
        .voltage_ctrl_o (volt),
        .meas_o         (meas),
        .locked_o       (locked),
        .busy_o         (busy),
        .fail_o         (fail)
    );

    always #5 clk = ~clk;

    // VCO model: free-running counter advancing by voltage plus drift offset
    always @(posedge clk) begin
        if (load) vco_count <= load_val;
        else      vco_count <= vco_count + CW'(volt) + offset;
    end

    task automatic do_reset(input logic [CW-1:0] preload);
        @(negedge clk);
        rst = 1'b1;
        load = 1'b1;
        load_val = preload;
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic send(input logic [CW-1:0] t);
        @(negedge clk);
        target = t;
        valid = 1'b1;
        @(posedge clk);
        #1 valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset('0);
        repeat (50) @(posedge clk);
        #1;
        checks++; if (volt !== '0) begin errors++; $display("FAIL reset_voltage got=%0d exp=0", volt); end
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", ready); end
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked got=%b exp=0", locked); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (fail !== 1'b0) begin errors++; $display("FAIL reset_fail got=%b exp=0", fail); end
        checks++; if (meas !== '0) begin errors++; $display("FAIL reset_meas got=%0d exp=0", meas); end
    endtask

    // Acquire 8000 from voltage 0: steps 250,375,437,468,484,492,496,498,499,500 then 4 hits
    task automatic test_lock(input string tag);
        int n;
        send(32'd8000);
        n = 0;
        while (locked !== 1'b1 && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 19) begin
                checks++; if (ready !== 1'b1) begin errors++; $display("FAIL %s_ready_measure got=%b exp=1", tag, ready); end
            end
            if (n == 20) begin
                checks++; if (ready !== 1'b0) begin errors++; $display("FAIL %s_ready_adjust got=%b exp=0", tag, ready); end
            end
            if (n == 41) begin
                checks++; if (meas !== 32'd4000) begin errors++; $display("FAIL %s_meas_window2 got=%0d exp=4000", tag, meas); end
            end
        end
        checks++; if (n != 294) begin errors++; $display("FAIL %s_lock_cycles got=%0d exp=294", tag, n); end
        checks++; if (volt !== 10'd500) begin errors++; $display("FAIL %s_lock_voltage got=%0d exp=500", tag, volt); end
        checks++; if (meas !== 32'd8000) begin errors++; $display("FAIL %s_lock_meas got=%0d exp=8000", tag, meas); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s_lock_busy got=%b exp=0", tag, busy); end
        checks++; if (fail !== 1'b0) begin errors++; $display("FAIL %s_lock_fail got=%b exp=0", tag, fail); end
    endtask

    // +3 counts/cycle drift: err -48 -> 499, -32 -> 498, -16 -> 497, then 4 on-target windows
    task automatic test_drift();
        int n;
        @(negedge clk);
        offset = 32'd3;
        n = 0;
        while (locked === 1'b1 && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++; if (n != 21) begin errors++; $display("FAIL drift_unlock_cycles got=%0d exp=21", n); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL drift_busy got=%b exp=1", busy); end
        checks++; if (volt !== 10'd499) begin errors++; $display("FAIL drift_first_step got=%0d exp=499", volt); end
        n = 0;
        while (locked !== 1'b1 && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++; if (n != 126) begin errors++; $display("FAIL drift_relock_cycles got=%0d exp=126", n); end
        checks++; if (volt !== 10'd497) begin errors++; $display("FAIL drift_voltage got=%0d exp=497", volt); end
        checks++; if (meas !== 32'd8000) begin errors++; $display("FAIL drift_meas got=%0d exp=8000", meas); end
    endtask

    // Unreachable target: one clipped step to 0x3FF, then failure at the rail
    task automatic test_fail();
        int n;
        @(negedge clk);
        offset = '0;
        do_reset('0);
        send(32'd2000000);
        n = 0;
        while (fail !== 1'b1 && n < 500) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 21) begin
                checks++; if (volt !== 10'h3FF) begin errors++; $display("FAIL fail_saturate got=%h exp=3ff", volt); end
            end
        end
        checks++; if (n != 42) begin errors++; $display("FAIL fail_cycles got=%0d exp=42", n); end
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL fail_locked got=%b exp=0", locked); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fail_busy got=%b exp=0", busy); end
        repeat (50) @(posedge clk);
        #1;
        checks++; if (fail !== 1'b1) begin errors++; $display("FAIL fail_hold got=%b exp=1", fail); end
        checks++; if (volt !== 10'h3FF) begin errors++; $display("FAIL fail_hold_voltage got=%h exp=3ff", volt); end
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL fail_ready got=%b exp=1", ready); end
    endtask

    // Preload chosen so the counter wraps inside the second window (start 2^32-1250, +4000)
    task automatic test_wrap();
        do_reset(32'hFFFF_F830);
        test_lock("wrap");
    endtask

    // Retarget mid-MEASURE: window restarts, so first new adjust lands 21 cycles later
    task automatic test_retarget();
        repeat (10) @(posedge clk);
        send(32'd4000);
        #1;
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL retarget_locked got=%b exp=0", locked); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL retarget_busy got=%b exp=1", busy); end
        for (int n = 1; n <= 21; n++) begin
            @(posedge clk);
            #1;
            if (n == 20) begin
                checks++; if (volt !== 10'd500) begin errors++; $display("FAIL retarget_hold got=%0d exp=500", volt); end
            end
            if (n == 21) begin
                checks++; if (volt !== 10'd375) begin errors++; $display("FAIL retarget_step got=%0d exp=375", volt); end
            end
        end
    endtask

    task automatic test_reset_mid();
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (volt !== '0) begin errors++; $display("FAIL midrst_voltage got=%0d exp=0", volt); end
        checks++; if (meas !== '0) begin errors++; $display("FAIL midrst_meas got=%0d exp=0", meas); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b exp=0", busy); end
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL midrst_ready got=%b exp=1", ready); end
        checks++; if (locked !== 1'b0 || fail !== 1'b0) begin
            errors++; $display("FAIL midrst_flags got=%b%b exp=00", locked, fail);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_lock("lock");
        test_drift();
        test_fail();
        test_wrap();
        test_retarget();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
